uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter.
REQ-002 Parameter DATA_W, default 8, byte width.
REQ-003 Parameter START_TIMEOUT, default 16, clocks allowed between tx_start and tx_busy rising.
REQ-004 clk  input  1  single system clock (50 MHz); all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester level request; held high until its grant bit pulses.
REQ-007 req_data  input  NUM_REQ*DATA_W  byte per requester; slice i = bits [i*DATA_W +: DATA_W].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted.
REQ-009 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data  output  DATA_W  byte presented to the transmitter; stable from grant until return to IDLE.
REQ-011 tx_busy  input  1  transmitter busy level.
REQ-012 tx_done  input  1  transmitter one-cycle completion pulse.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the granted byte completes.
REQ-015 done_id  output  $clog2(NUM_REQ)  index of the completed requester; valid with done, holds its value otherwise.
REQ-016 timeout_err  output  1  one-cycle pulse when tx_busy fails to rise in time.

Function
REQ-017 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE, any req bit high: round-robin pick starting at last_id+1 (wrapping NUM_REQ-1 -> 0); at the next edge grant pulses, tx_data latches the winner's slice, FSM -> START.
REQ-019 START: tx_start high for exactly this one cycle; timeout counter cleared; -> WAIT_BUSY.
REQ-020 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; tx_done=1 (same cycle or alone) -> completion per REQ-022; counter reaches START_TIMEOUT -> timeout_err pulse, -> IDLE, no done.
REQ-021 tx_done has priority over timeout in the same cycle.
REQ-022 WAIT_DONE: tx_done=1 -> done pulse with done_id = granted index, last_id updated, -> IDLE.
REQ-023 last_id is updated on completion and on timeout, so the timed-out requester loses priority.
REQ-024 req seen while not IDLE is not granted and not lost: it stays pending while held high.
REQ-025 Request-to-tx_start latency is 2 clocks; done-to-next-grant is 1 clock (IDLE re-evaluates on the cycle after done).
REQ-026 req deassert after grant has no effect on the transfer in flight; req_data is sampled only at grant.
REQ-027 tx_busy/tx_done in IDLE or START are ignored.
REQ-028 Timeout counter width is $clog2(START_TIMEOUT+1); it saturates and never wraps.

Reset
REQ-029 rst=1 at any edge (including mid-transfer): FSM -> IDLE; grant, tx_start, tx_data, busy, done, done_id, timeout_err, counter = 0; last_id = NUM_REQ-1 (requester 0 has first priority).
REQ-030 The first edge after rst deasserts may issue a grant.

Structure
REQ-031 Shared package uart_pkg holds the FSM state encoding and default constants NUM_REQ, DATA_W, START_TIMEOUT.
REQ-032 One sub-module rr_pick (combinational: req vector and last_id in, one-hot winner and index out); the arbiter holds all registers.

Verification
REQ-033 Single request: req=4'b0100, data2=8'hA5 -> grant=4'b0100 at +1, tx_start at +2, tx_data=8'hA5; after tx_busy then tx_done, done=1 and done_id=2.
REQ-034 Fairness: req=4'b1111 held, loopback transmitter -> grant order 0,1,2,3,0 with done_id matching.
REQ-035 Timeout: tx_busy held 0 after tx_start -> timeout_err pulse exactly START_TIMEOUT clocks after WAIT_BUSY entry, no done, next grant goes to the following requester.
REQ-036 Same-cycle tx_busy=1 and tx_done=1 in WAIT_BUSY -> done pulse, no timeout_err.
REQ-037 rst pulsed during WAIT_DONE -> all outputs 0 the next cycle; with req=4'b1010 after release, the first grant is 4'b0010.
REQ-038 Loopback 9600 baud at 50 MHz: 3 queued bytes 8'h55, 8'h0F, 8'hC3 -> received in that order with a correct done per byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - default sizing constants (requesters, byte width, start timeout)
//   - FSM state encoding used by uart_tx_arbiter
package uart_pkg;

  localparam int NUM_REQ       = 4;
  localparam int DATA_W        = 8;
  localparam int START_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req      : request vector
//   last_id  : index served last; search starts at last_id+1 and wraps
//   pick_gnt : one-hot winner (all zero when no request)
//   pick_idx : winner index
//   pick_vld : at least one request present
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = uart_pkg::NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_id,
  output logic [NUM_REQ-1:0] pick_gnt,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_vld
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] cand;
    j        = 0;
    cand     = '0;
    pick_gnt = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    // Walk the ring once starting just after last_id; first hit wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      j    = (int'(last_id) + k) % NUM_REQ;
      cand = IDX_W'(j);
      if (!pick_vld && req[cand]) begin
        pick_vld       = 1'b1;
        pick_idx       = cand;
        pick_gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
//   clk, rst        : system clock, synchronous active-high reset
//   req, req_data   : per-requester level request and byte (slice i)
//   grant           : one-hot one-cycle pulse when a byte is accepted
//   tx_start        : one-cycle start pulse to the transmitter
//   tx_data         : byte presented to the transmitter
//   tx_busy,tx_done : transmitter busy level and completion pulse
//   busy            : arbiter not idle
//   done, done_id   : completion pulse and index of the finished requester
//   timeout_err     : transmitter never raised busy after tx_start
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = uart_pkg::NUM_REQ,
  parameter int DATA_W        = uart_pkg::DATA_W,
  parameter int START_TIMEOUT = uart_pkg::START_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_REQ)-1:0]  done_id,
  output logic                        timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last_id, gnt_id, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_vld;
  logic [CNT_W-1:0]   to_cnt;
  logic               xfer_end, to_hit;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req      (req),
    .last_id  (last_id),
    .pick_gnt (pick_gnt),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // tx_done wins over the timeout, and busy/done are only heard while waiting.
  assign xfer_end = tx_done && (state == ST_WAIT_BUSY || state == ST_WAIT_DONE);
  // The edge on which the counter would reach START_TIMEOUT ends the wait.
  assign to_hit   = (state == ST_WAIT_BUSY) && !tx_done && !tx_busy && (to_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (pick_vld) state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_done)      state_nxt = ST_IDLE;
        else if (tx_busy) state_nxt = ST_WAIT_DONE;
        else if (to_hit)  state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (tx_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Registered pulses, latched byte, counter and priority pointer.
  // tx_start is registered off START so it lands two clocks after req.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      done        <= 1'b0;
      done_id     <= '0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
      gnt_id      <= '0;
      last_id     <= IDX_W'(NUM_REQ - 1);
    end else begin
      grant       <= '0;
      tx_start    <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;

      if (state == ST_IDLE && pick_vld) begin
        grant   <= pick_gnt;
        gnt_id  <= pick_idx;
        tx_data <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
      end

      if (state == ST_START) begin
        tx_start <= 1'b1;
        to_cnt   <= '0;
      end

      if (state == ST_WAIT_BUSY && !tx_done && !tx_busy && to_cnt != CNT_MAX)
        to_cnt <= to_cnt + 1'b1;

      if (xfer_end) begin
        done    <= 1'b1;
        done_id <= gnt_id;
        last_id <= gnt_id;
      end else if (to_hit) begin
        // Timed-out requester drops to lowest priority.
        timeout_err <= 1'b1;
        last_id     <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference
// model compared every cycle, plus hand-computed directed checks.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int T   = 16;
  localparam int CPB = 8;   // shortened bit period; framing is real 8N1

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     grant;
  logic             tx_start;
  logic [W-1:0]     tx_data;
  logic             tx_busy, tx_done;
  logic             busy, done, timeout_err;
  logic [1:0]       done_id;

  logic man_busy, man_done, lb_en, lb_busy, lb_done, auto_clr;
  logic rx_line = 1'b1;

  int checks = 0;
  int errors = 0;

  int        glog[$];
  int        dlog[$];
  logic [7:0] rxq[$];

  assign tx_busy = lb_en ? lb_busy : man_busy;
  assign tx_done = lb_en ? lb_done : man_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .START_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .busy(busy), .done(done), .done_id(done_id), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  bit         m_valid = 0;
  bit         m_act;
  int         m_own, m_age, m_ws, m_last;
  bit         m_seen;
  logic [N-1:0] m_grant;
  logic       m_start, m_done, m_to;
  logic [W-1:0] m_data;
  int         m_did;

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    m_grant = '0; m_start = 0; m_done = 0; m_to = 0;
    if (rst) begin
      m_valid = 1; m_act = 0; m_last = N - 1; m_data = '0; m_did = 0;
    end else if (!m_act) begin
      if (req != '0) begin
        m_own = rr(req, m_last);
        m_act = 1; m_age = 0; m_ws = 0; m_seen = 0;
        m_grant[m_own] = 1'b1;
        m_data = req_data[m_own*W +: W];
      end
    end else begin
      m_age++;
      if (m_age == 1) m_start = 1;              // start pulse; transmitter ignored
      else if (tx_done) begin
        m_done = 1; m_did = m_own; m_last = m_own; m_act = 0;
      end else if (!m_seen && tx_busy) m_seen = 1;
      else if (!m_seen) begin
        m_ws++;
        if (m_ws == T) begin m_to = 1; m_last = m_own; m_act = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("grant", grant, m_grant);
      chk("tx_start", tx_start, m_start);
      chk("tx_data", tx_data, m_data);
      chk("busy", busy, m_act);
      chk("done", done, m_done);
      chk("done_id", done_id, m_did);
      chk("timeout_err", timeout_err, m_to);
    end
  end

  // ---------------- loopback transmitter and receiver ----------------
  initial begin
    lb_busy = 0; lb_done = 0;
    forever begin
      @(negedge clk);
      if (lb_en && tx_start) begin
        logic [7:0] sh;
        sh = tx_data;
        lb_busy = 1;
        for (int i = 0; i < 10; i++) begin
          rx_line = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : sh[i-1];
          repeat (CPB) @(negedge clk);
        end
        lb_busy = 0; lb_done = 1;
        @(negedge clk);
        lb_done = 0;
      end
    end
  end

  initial begin
    forever begin
      logic [7:0] sh;
      @(negedge rx_line);
      repeat (CPB/2) @(negedge clk);
      if (rx_line == 1'b0) begin
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          sh[b] = rx_line;
        end
        repeat (CPB) @(negedge clk);
        chk("rx_stop_bit", rx_line, 1'b1);
        rxq.push_back(sh);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
    if (done) dlog.push_back(int'(done_id));
    if (auto_clr) req = req & ~grant;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || req != '0) && n < budget) begin tick(); n++; end
    chk("wait_idle_bound", (n < budget), 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1; req = '0; req_data = '0; man_busy = 0; man_done = 0;
    lb_en = 0; auto_clr = 1;
    repeat (3) tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_done_id", done_id, 2'd0);
    chk("rst_timeout", timeout_err, 1'b0);
    rst = 0;

    // single request on requester 2
    req_data = 32'h00A5_0000; req = 4'b0100;
    tick();
    chk("single_grant", grant, 4'b0100);
    chk("single_no_start_yet", tx_start, 1'b0);
    tick();
    chk("single_tx_start", tx_start, 1'b1);
    chk("single_tx_data", tx_data, 8'hA5);
    man_busy = 1;
    repeat (3) tick();
    man_busy = 0; man_done = 1;
    tick();
    man_done = 0;
    chk("single_done", done, 1'b1);
    chk("single_done_id", done_id, 2'd2);
    tick();
    chk("single_idle", busy, 1'b0);

    // timeout on requester 3, which must then yield to requester 0
    auto_clr = 0; req = 4'b1001;
    tick();
    chk("to_grant", grant, 4'b1000);
    tick();
    chk("to_tx_start", tx_start, 1'b1);
    n = 0;
    while (!timeout_err && n < 40) begin tick(); n++; end
    chk("to_latency", n, T);
    chk("to_no_done", done, 1'b0);
    tick();
    chk("to_next_grant", grant, 4'b0001);
    req = '0;
    tick();
    // busy and done together while waiting for busy
    man_busy = 1; man_done = 1;
    tick();
    man_busy = 0; man_done = 0;
    chk("same_cycle_done", done, 1'b1);
    chk("same_cycle_no_to", timeout_err, 1'b0);
    chk("same_cycle_id", done_id, 2'd0);
    auto_clr = 1;

    // reset in WAIT_DONE, then 4'b1010 must grant requester 1 first
    req = 4'b0100;
    tick(); tick();
    man_busy = 1;
    tick(); tick();
    rst = 1;
    tick();
    chk("mid_rst_grant", grant, 4'b0000);
    chk("mid_rst_start", tx_start, 1'b0);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_id", done_id, 2'd0);
    rst = 0; man_busy = 0; req = 4'b1010;
    tick();
    chk("post_rst_grant", grant, 4'b0010);
    lb_en = 1;
    wait_idle(1000);

    // fairness: all four held, loopback transmitter
    glog.delete(); dlog.delete();
    auto_clr = 0; req = 4'b1111;
    n = 0;
    while (glog.size() < 5 && n < 3000) begin tick(); n++; end
    req = '0;
    wait_idle(1000);
    chk("fair_count", glog.size(), 5);
    chk("fair_dcount", dlog.size(), 5);
    if (glog.size() == 5 && dlog.size() == 5) begin
      chk("fair_g0", glog[0], 0); chk("fair_g1", glog[1], 1);
      chk("fair_g2", glog[2], 2); chk("fair_g3", glog[3], 3);
      chk("fair_g4", glog[4], 0);
      for (int i = 0; i < 5; i++) chk("fair_done_id", dlog[i], glog[i]);
    end

    // three queued bytes through the loopback line
    glog.delete(); dlog.delete(); rxq.delete();
    auto_clr = 1; req_data = 32'hC30F_5500; req = 4'b1110;
    n = 0;
    while (rxq.size() < 3 && n < 3000) begin tick(); n++; end
    wait_idle(1000);
    chk("rx_count", rxq.size(), 3);
    chk("rx_dcount", dlog.size(), 3);
    if (rxq.size() == 3 && dlog.size() == 3) begin
      chk("rx_b0", rxq[0], 8'h55);
      chk("rx_b1", rxq[1], 8'h0F);
      chk("rx_b2", rxq[2], 8'hC3);
      chk("rx_id0", dlog[0], 1);
      chk("rx_id1", dlog[1], 2);
      chk("rx_id2", dlog[2], 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
